// File: rtl/scdb_readout.sv
// Drains completed waveforms from the secondary buffer into a 16-bit valid/ready frame stream.
// Latency: header pop to first word 1 cycle; data request to first data word 2 cycles.
// Backpressure: out_ready low freezes the current word; buffer reads are only issued between words.
module scdb_readout #(
    parameter int P_HDR_WIDTH  = 113,
    parameter int P_DATA_WIDTH = 85,
    parameter int P_MAX_WORDS  = 512,
    parameter int P_CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    buf_hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  buf_hdr_data,
    output logic                    buf_hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] buf_data,
    output logic                    buf_rdreq,
    output logic                    buf_rddone,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun,
    output logic [P_CNT_WIDTH-1:0]  frame_cnt
);

    localparam int WC_W = $clog2(P_MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_SEND,
        S_DATA_REQ,
        S_DATA_WAIT,
        S_DATA_SEND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [127:0]           shift_q, shift_d;
    logic [2:0]             word_idx_q, word_idx_d;
    logic [WC_W-1:0]        word_cnt_q, word_cnt_d;
    logic                   flag_q, flag_d;
    logic                   overrun_q, overrun_d;
    logic [P_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    logic start;
    logic accept;
    logic term;
    logic hdr_end;
    logic data_end;

    assign start    = en && !buf_hdr_empty;
    assign accept   = out_valid && out_ready;
    // A waveform ends on its flagged word or when the word budget is exhausted.
    assign term     = flag_q || (word_cnt_q == WC_W'(P_MAX_WORDS));
    assign hdr_end  = accept && (word_idx_q == 3'd7);
    assign data_end = accept && (word_idx_q == 3'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            word_idx_q  <= '0;
            word_cnt_q  <= '0;
            flag_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            word_idx_q  <= word_idx_d;
            word_cnt_q  <= word_cnt_d;
            flag_q      <= flag_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_HDR_SEND;
            S_HDR_SEND:  if (hdr_end) state_d = S_DATA_REQ;
            S_DATA_REQ:  state_d = S_DATA_WAIT;
            S_DATA_WAIT: state_d = S_DATA_SEND;
            S_DATA_SEND: if (data_end) state_d = term ? S_DONE : S_DATA_REQ;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        word_idx_d  = word_idx_q;
        word_cnt_d  = word_cnt_q;
        flag_d      = flag_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = 128'(buf_hdr_data);
                    word_idx_d = '0;
                    word_cnt_d = '0;
                    flag_d     = 1'b0;
                end
            end
            S_HDR_SEND: begin
                if (accept) begin
                    shift_d    = {shift_q[111:0], 16'h0000};
                    word_idx_d = hdr_end ? 3'd0 : word_idx_q + 3'd1;
                end
            end
            S_DATA_REQ: begin
                word_cnt_d = word_cnt_q + WC_W'(1);
            end
            S_DATA_WAIT: begin
                // Data word sits in the top 96 bits so words shift out of the same window as the header.
                shift_d    = {96'(buf_data), 32'h0000_0000};
                flag_d     = buf_data[P_DATA_WIDTH-1];
                word_idx_d = '0;
            end
            S_DATA_SEND: begin
                if (accept) begin
                    shift_d    = {shift_q[111:0], 16'h0000};
                    word_idx_d = data_end ? 3'd0 : word_idx_q + 3'd1;
                    if (data_end && term && !flag_q) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + P_CNT_WIDTH'(1);
            end
            default: begin
                shift_d = shift_q;
            end
        endcase
    end

    // Outputs are forced low while rst is held so the stream and buffer strobes are quiet in reset.
    always_comb begin
        out_valid     = 1'b0;
        out_data      = 16'h0000;
        out_last      = 1'b0;
        buf_hdr_rdreq = 1'b0;
        buf_rdreq     = 1'b0;
        buf_rddone    = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            out_valid     = (state_q == S_HDR_SEND) || (state_q == S_DATA_SEND);
            out_data      = out_valid ? shift_q[127:112] : 16'h0000;
            out_last      = (state_q == S_DATA_SEND) && (word_idx_q == 3'd5) && term;
            buf_hdr_rdreq = (state_q == S_IDLE) && start;
            buf_rdreq     = (state_q == S_DATA_REQ);
            buf_rddone    = (state_q == S_DONE);
            busy          = (state_q != S_IDLE);
        end
    end

    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_scdb_readout.sv
// Randomized bench for scdb_readout: a secondary-buffer model feeds waveforms, a scoreboard checks the frame stream.
module tb_scdb_readout;

    localparam int HW   = 113;
    localparam int DW   = 85;
    localparam int MAXW = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst, en, buf_hdr_empty, buf_hdr_rdreq, buf_rdreq, buf_rddone;
    logic [HW-1:0] buf_hdr_data;
    logic [DW-1:0] buf_data;
    logic [15:0]   out_data;
    logic          out_valid, out_ready, out_last, busy, overrun;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    scdb_readout #(
        .P_HDR_WIDTH (HW),
        .P_DATA_WIDTH(DW),
        .P_MAX_WORDS (MAXW),
        .P_CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .buf_hdr_empty(buf_hdr_empty),
        .buf_hdr_data (buf_hdr_data),
        .buf_hdr_rdreq(buf_hdr_rdreq),
        .buf_data     (buf_data),
        .buf_rdreq    (buf_rdreq),
        .buf_rddone   (buf_rddone),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .overrun      (overrun),
        .frame_cnt    (frame_cnt)
    );

    int checks = 0;
    int passed = 0;

    logic [HW-1:0] hdr_fifo[$];
    logic [DW-1:0] data_fifo[$];
    int            len_fifo[$];
    logic [17:0]   exp_q[$];      // {first_of_frame, last, data}
    bit            exp_ovr_q[$];

    int  cyc = 0;
    int  hdr_n = 0, rd_n = 0, done_n = 0, words_acc = 0, frames_done = 0;
    int  t_hdr = -1000, t_rd = -1000, t_done = -1000;
    int  gap_hdr_rd = 0, gap_rd_rd = 0, gap_done_hdr = 0;
    bit  rd_since_hdr = 0;
    bit  ovr_model = 0;
    bit  pend_hdr = 0, pend_rd = 0, pend_done = 0;
    int  ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string what);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s", what);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    function automatic logic [HW-1:0] rand_hdr();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[HW-1:0];
    endfunction

    // Reference: a waveform of n words is read up to its flag, or MAXW words if unflagged.
    task automatic enqueue_wave(input logic [HW-1:0] hdr, input int n, input bit flagged);
        logic [127:0]  h;
        logic [95:0]   d;
        logic [DW-1:0] w;
        int            nread;
        hdr_fifo.push_back(hdr);
        len_fifo.push_back(n);
        h = {15'b0, hdr};
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 0), 1'b0, h[127-16*i -: 16]});
        nread = flagged ? n : MAXW;
        for (int j = 0; j < n; j++) begin
            w = rand_word();
            w[DW-1] = flagged && (j == n - 1);
            data_fifo.push_back(w);
            if (j < nread) begin
                d = {11'b0, w};
                for (int i = 0; i < 6; i++)
                    exp_q.push_back({1'b0, (j == nread - 1) && (i == 5), d[95-16*i -: 16]});
            end
        end
        exp_ovr_q.push_back(!flagged);
    endtask

    task automatic enqueue_random();
        int n;
        bit f;
        n = $urandom_range(1, MAXW + 2);
        f = (n < MAXW) ? 1'b1 : (n > MAXW) ? 1'b0 : 1'($urandom_range(0, 1));
        enqueue_wave(rand_hdr(), n, f);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(frames_done >= target, $sformatf("frame_timeout frames=%0d required=%0d", frames_done, target));
        #2;
    endtask

    // Secondary buffer model: acts on strobes seen in the previous cycle, just after the clock edge.
    initial begin
        int            cur_rem;
        logic [DW-1:0] dummy;
        cur_rem = 0;
        buf_hdr_empty = 1'b1;
        buf_hdr_data = '0;
        buf_data = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hdr_fifo.delete();
                data_fifo.delete();
                len_fifo.delete();
                cur_rem = 0;
            end else begin
                buf_data = rand_word();
                if (pend_rd) begin
                    check(cur_rem > 0, $sformatf("overread remaining=%0d required>0", cur_rem));
                    if (cur_rem > 0) begin
                        buf_data = data_fifo.pop_front();
                        cur_rem--;
                    end
                end
                if (pend_hdr) begin
                    check(hdr_fifo.size() > 0, $sformatf("hdr_pop_empty size=%0d required>0", hdr_fifo.size()));
                    if (hdr_fifo.size() > 0) begin
                        dummy = DW'(hdr_fifo.pop_front());
                        cur_rem = len_fifo.pop_front();
                    end
                end
                if (pend_done) begin
                    while (cur_rem > 0) begin
                        dummy = data_fifo.pop_front();
                        cur_rem--;
                    end
                end
            end
            buf_hdr_empty = (hdr_fifo.size() == 0);
            buf_hdr_data  = (hdr_fifo.size() > 0) ? hdr_fifo[0] : rand_hdr();
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [17:0] e;
        bit          prev_stall, chk_frame;
        logic [15:0] st_data;
        logic        st_last;
        int          npulse;
        prev_stall = 0;
        chk_frame = 0;
        st_data = '0;
        st_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_ovr_q.delete();
                ovr_model = 0;
                frames_done = 0;
                prev_stall = 0;
                chk_frame = 0;
                pend_hdr = 0;
                pend_rd = 0;
                pend_done = 0;
            end else begin
                if (chk_frame) begin
                    check(frame_cnt == CW'(frames_done), $sformatf("frame_cnt got=%0d required=%0d", frame_cnt, CW'(frames_done)));
                    check(overrun == ovr_model, $sformatf("overrun got=%0b required=%0b", overrun, ovr_model));
                    chk_frame = 0;
                end
                npulse = int'(buf_hdr_rdreq) + int'(buf_rdreq) + int'(buf_rddone);
                if (npulse > 0)
                    check(npulse == 1, $sformatf("strobe_overlap got=%0d strobes required=1", npulse));
                if (buf_hdr_rdreq) begin
                    hdr_n++;
                    gap_done_hdr = cyc - t_done;
                    t_hdr = cyc;
                    rd_since_hdr = 0;
                end
                if (buf_rdreq) begin
                    rd_n++;
                    if (!rd_since_hdr) gap_hdr_rd = cyc - t_hdr;
                    else gap_rd_rd = cyc - t_rd;
                    t_rd = cyc;
                    rd_since_hdr = 1;
                end
                if (buf_rddone) begin
                    done_n++;
                    frames_done++;
                    t_done = cyc;
                    if (exp_ovr_q.size() > 0) ovr_model = ovr_model | exp_ovr_q.pop_front();
                    chk_frame = 1;
                end
                pend_hdr  = buf_hdr_rdreq;
                pend_rd   = buf_rdreq;
                pend_done = buf_rddone;
                if (prev_stall)
                    check(out_valid && out_data == st_data && out_last == st_last,
                          $sformatf("stall_hold got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                                    out_valid, out_data, out_last, st_data, st_last));
                if (out_valid && out_ready) begin
                    words_acc++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, $sformatf("extra_word got d=%h l=%0b required none", out_data, out_last));
                    end else begin
                        e = exp_q.pop_front();
                        check({out_last, out_data} == e[16:0],
                              $sformatf("word got d=%h l=%0b required d=%h l=%0b", out_data, out_last, e[15:0], e[16]));
                        if (e[17])
                            check(cyc - t_done >= 2, $sformatf("frame_start_gap got=%0d required>=2", cyc - t_done));
                    end
                end
                prev_stall = out_valid && !out_ready;
                st_data = out_data;
                st_last = out_last;
            end
        end
    end

    initial begin
        logic [HW-1:0] h;
        int bh, br, bd, bw, en_cyc, k;
        rst = 1'b1;
        en = 1'b0;
        tick(3);
        @(negedge clk);
        check({out_valid, out_last, out_data, busy, overrun, frame_cnt, buf_hdr_rdreq, buf_rdreq, buf_rddone} == '0,
              $sformatf("reset_outputs got v=%0b d=%h busy=%0b ovr=%0b fc=%0d required all 0",
                        out_valid, out_data, busy, overrun, frame_cnt));
        tick(1);
        rst = 1'b0;

        // Three-word frame, flag on the third word, ready held high.
        h = rand_hdr();
        h[15:0] = 16'h1234;
        bh = hdr_n; br = rd_n; bd = done_n; bw = words_acc;
        enqueue_wave(h, 3, 1'b1);
        en = 1'b1;
        wait_frames(1, 500);
        tick(2);
        check(hdr_n - bh == 1, $sformatf("t1_hdr_rdreq got=%0d required=1", hdr_n - bh));
        check(rd_n - br == 3, $sformatf("t1_rdreq got=%0d required=3", rd_n - br));
        check(done_n - bd == 1, $sformatf("t1_rddone got=%0d required=1", done_n - bd));
        check(words_acc - bw == 26, $sformatf("t1_words got=%0d required=26", words_acc - bw));
        check(gap_hdr_rd == 9, $sformatf("t1_hdr_to_rd got=%0d required=9", gap_hdr_rd));
        check(gap_rd_rd == 8, $sformatf("t1_rd_to_rd got=%0d required=8", gap_rd_rd));

        // Same stimulus with ready toggling.
        ready_mode = 1;
        br = rd_n; bw = words_acc;
        enqueue_wave(h, 3, 1'b1);
        wait_frames(2, 1000);
        tick(2);
        check(rd_n - br == 3, $sformatf("t2_rdreq got=%0d required=3", rd_n - br));
        check(words_acc - bw == 26, $sformatf("t2_words got=%0d required=26", words_acc - bw));

        // Two frames back-to-back.
        ready_mode = 0;
        enqueue_random();
        enqueue_random();
        wait_frames(4, 1000);
        tick(2);
        check(gap_done_hdr == 1, $sformatf("t3_done_to_hdr got=%0d required=1", gap_done_hdr));
        check(frame_cnt == CW'(4), $sformatf("t3_frame_cnt got=%0d required=4", frame_cnt));

        // Unflagged waveform longer than the word budget.
        br = rd_n; bd = done_n; bw = words_acc;
        enqueue_wave(rand_hdr(), MAXW + 2, 1'b0);
        wait_frames(5, 1000);
        tick(2);
        check(rd_n - br == MAXW, $sformatf("t4_rdreq got=%0d required=%0d", rd_n - br, MAXW));
        check(words_acc - bw == 8 + 6 * MAXW, $sformatf("t4_words got=%0d required=%0d", words_acc - bw, 8 + 6 * MAXW));
        check(overrun == 1'b1, $sformatf("t4_overrun got=%0b required=1", overrun));
        check(done_n - bd == 1, $sformatf("t4_rddone got=%0d required=1", done_n - bd));

        // en low blocks starts.
        en = 1'b0;
        bh = hdr_n; br = rd_n; bd = done_n;
        enqueue_wave(rand_hdr(), 2, 1'b1);
        tick(100);
        check((hdr_n - bh) + (rd_n - br) + (done_n - bd) == 0,
              $sformatf("t5_idle_strobes got=%0d required=0", (hdr_n - bh) + (rd_n - br) + (done_n - bd)));
        en = 1'b1;
        en_cyc = cyc;
        wait_frames(6, 1000);
        check(t_hdr == en_cyc, $sformatf("t5_start_cycle got=%0d required=%0d", t_hdr, en_cyc));

        // Reset in the middle of DATA_SEND.
        br = rd_n;
        enqueue_wave(rand_hdr(), 3, 1'b1);
        k = 0;
        while (rd_n == br && k < 200) begin
            @(posedge clk);
            k++;
        end
        check(rd_n > br, $sformatf("t6_first_rdreq got=%0d required>%0d", rd_n, br));
        tick(2);
        rst = 1'b1;
        bd = done_n;
        @(posedge clk);
        @(negedge clk);
        check({out_valid, out_last, out_data, busy, overrun, frame_cnt, buf_hdr_rdreq, buf_rdreq, buf_rddone} == '0,
              $sformatf("t6_reset_outputs got v=%0b d=%h busy=%0b ovr=%0b fc=%0d required all 0",
                        out_valid, out_data, busy, overrun, frame_cnt));
        tick(1);
        rst = 1'b0;
        tick(20);
        check(done_n == bd, $sformatf("t6_rddone got=%0d required=%0d", done_n, bd));
        check(busy == 1'b0 && frame_cnt == '0, $sformatf("t6_idle got busy=%0b fc=%0d required 0/0", busy, frame_cnt));

        // Random traffic with random backpressure and en; 20 frames wraps the 4-bit counter.
        ready_mode = 2;
        for (int i = 0; i < 20; i++) enqueue_random();
        for (int i = 0; i < 600; i++) begin
            tick(1);
            en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
        wait_frames(20, 20000);
        tick(3);
        check(frame_cnt == CW'(20), $sformatf("t7_frame_cnt got=%0d required=%0d", frame_cnt, CW'(20)));
        check(exp_q.size() == 0, $sformatf("t7_leftover got=%0d words required=0", exp_q.size()));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
